// File: rtl/cic_interp_if.sv
// Sample stream bundle for cic_interp: input handshake (data/valid/ready) and output sample stream.
// Member names are seen from the filter's side, so the slave modport matches the filter's ports.
interface cic_interp_if #(
   parameter int unsigned DATAIN_WIDTH  = 16,
   parameter int unsigned DATAOUT_WIDTH = DATAIN_WIDTH
);
   logic [DATAIN_WIDTH-1:0]  data_i;
   logic                     valid_i;
   logic                     ready_o;
   logic [DATAOUT_WIDTH-1:0] data_o;
   logic                     valid_o;

   modport master (
      output data_i,
      output valid_i,
      input  ready_o,
      input  data_o,
      input  valid_o
   );

   modport slave (
      input  data_i,
      input  valid_i,
      output ready_o,
      output data_o,
      output valid_o
   );
endinterface

// File: rtl/cic_interp.sv
// N-stage CIC interpolator: low-rate comb chain, zero-stuffing, high-rate integrator chain.
// Define CIC_INTERP_ROUND_EN for round-half-up, saturating output slicing instead of truncation.
module cic_interp #(
   parameter int unsigned DATAIN_WIDTH  = 16,
   parameter int unsigned DATAOUT_WIDTH = DATAIN_WIDTH,
   parameter int unsigned M             = 1,
   parameter int unsigned N             = 5,
   parameter int unsigned MAXRATE       = 64,
   parameter int unsigned RATE_WIDTH    = 7,
   parameter int unsigned bitgrowth     = 24
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  en_i,
   input  logic [RATE_WIDTH-1:0] rate_i,
   cic_interp_if.slave           bus_io,
   output logic                  underrun_o
);
   localparam int unsigned W = DATAIN_WIDTH + bitgrowth;
   typedef logic signed [W-1:0] acc_t;

   logic [RATE_WIDTH-1:0]   rate_q, rate_d, phase_q, phase_d, rate_clamped;
   logic                    full_q, full_d;
   logic [DATAIN_WIDTH-1:0] buf_q, buf_d, src;
   logic                    underrun_q, underrun_d, valid_q;
   logic                    strobe, xfer;
   acc_t                    x;
   acc_t                    comb_q [N];
   acc_t                    comb_d [N];
   acc_t                    dly_q [N][M];
   acc_t                    dly_d [N][M];
   acc_t                    integ_q [N];
   acc_t                    integ_d [N];
   logic [DATAOUT_WIDTH-1:0] data_out;

   always_comb begin
      if (rate_i < RATE_WIDTH'(2)) begin
         rate_clamped = RATE_WIDTH'(2);
      end else if (32'(rate_i) > MAXRATE) begin
         rate_clamped = RATE_WIDTH'(MAXRATE);
      end else begin
         rate_clamped = rate_i;
      end
   end

   assign strobe = en_i && (phase_q == '0);
   assign xfer   = bus_io.valid_i && !full_q;

   // Phase counter; the ratio only changes at a wrap so a period is never cut short.
   always_comb begin
      phase_d = phase_q;
      rate_d  = rate_q;
      if (en_i) begin
         if (phase_q >= rate_q - RATE_WIDTH'(1)) begin
            phase_d = '0;
            rate_d  = rate_clamped;
         end else begin
            phase_d = phase_q + RATE_WIDTH'(1);
         end
      end
   end

   always_comb begin
      full_d     = full_q;
      buf_d      = buf_q;
      underrun_d = 1'b0;
      src        = '0;
      if (strobe) begin
         if (full_q) begin
            src    = buf_q;
            full_d = 1'b0;
         end else if (xfer) begin
            src = bus_io.data_i;
         end else begin
            underrun_d = 1'b1;
         end
      end else if (xfer) begin
         buf_d  = bus_io.data_i;
         full_d = 1'b1;
      end
   end

   assign x = {{bitgrowth{src[DATAIN_WIDTH-1]}}, src};

   always_comb begin
      comb_d = comb_q;
      dly_d  = dly_q;
      if (strobe) begin
         comb_d[0]   = x - dly_q[0][M-1];
         dly_d[0][0] = x;
         for (int k = 1; k < M; k++) dly_d[0][k] = dly_q[0][k-1];
         for (int i = 1; i < N; i++) begin
            comb_d[i]   = comb_q[i-1] - dly_q[i][M-1];
            dly_d[i][0] = comb_q[i-1];
            for (int k = 1; k < M; k++) dly_d[i][k] = dly_q[i][k-1];
         end
      end
   end

   // Comb output enters only on phase 0: this is the zero-stuffing.
   always_comb begin
      integ_d = integ_q;
      if (en_i) begin
         integ_d[0] = integ_q[0] + ((phase_q == '0) ? comb_q[N-1] : acc_t'(0));
         for (int j = 1; j < N; j++) integ_d[j] = integ_q[j] + integ_q[j-1];
      end
   end

`ifdef CIC_INTERP_ROUND_EN
   localparam logic [W:0] Half = (W+1)'(1) << (W - DATAOUT_WIDTH - 1);
   logic [W:0] rnd_sum;

   always_comb begin
      rnd_sum = {integ_q[N-1][W-1], integ_q[N-1]} + Half;
      if (rnd_sum[W] != rnd_sum[W-1]) begin
         data_out = {1'b0, {(DATAOUT_WIDTH-1){1'b1}}};
      end else begin
         data_out = rnd_sum[W-1 -: DATAOUT_WIDTH];
      end
   end
`else
   assign data_out = integ_q[N-1][W-1 -: DATAOUT_WIDTH];
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rate_q     <= rate_clamped;
         phase_q    <= '0;
         full_q     <= 1'b0;
         buf_q      <= '0;
         underrun_q <= 1'b0;
         valid_q    <= 1'b0;
         for (int i = 0; i < N; i++) begin
            comb_q[i]  <= '0;
            integ_q[i] <= '0;
            for (int k = 0; k < M; k++) dly_q[i][k] <= '0;
         end
      end else begin
         rate_q     <= rate_d;
         phase_q    <= phase_d;
         full_q     <= full_d;
         buf_q      <= buf_d;
         underrun_q <= underrun_d;
         valid_q    <= en_i;
         comb_q     <= comb_d;
         dly_q      <= dly_d;
         integ_q    <= integ_d;
      end
   end

   assign bus_io.ready_o = !full_q;
   assign bus_io.valid_o = valid_q;
   assign bus_io.data_o  = data_out;
   assign underrun_o     = underrun_q;
endmodule

// File: tb/tb_cic_interp.sv
// Directed bench for cic_interp: reset, DC gain, rounding, underrun/bypass, backpressure, rate changes.
module tb_cic_interp;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [6:0] rate;
   logic       underrun;
   int         n_checks;
   int         n_errors;
   int         n_underrun;
   int         n_xfer;
   logic       did_xfer;

   always #5 clk = ~clk;

   cic_interp_if #(.DATAIN_WIDTH(16), .DATAOUT_WIDTH(16)) bus ();

   cic_interp dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .en_i       (en),
      .rate_i     (rate),
      .bus_io     (bus),
      .underrun_o (underrun)
   );

`ifdef CIC_INTERP_ROUND_EN
   localparam logic [15:0] ExpFrac = 16'd2;
   localparam logic [15:0] ExpNeg  = 16'h0000;
`else
   localparam logic [15:0] ExpFrac = 16'd1;
   localparam logic [15:0] ExpNeg  = 16'hFFFF;
`endif

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (underrun === 1'b1) n_underrun++;
   endtask

   task automatic restart(input logic [6:0] r, input logic [15:0] d, input logic v);
      rst_n       = 1'b0;
      en          = 1'b1;
      rate        = r;
      bus.data_i  = d;
      bus.valid_i = v;
      step();
      step();
      rst_n      = 1'b1;
      n_underrun = 0;
   endtask

   task automatic steady_check(input string tag, input logic [15:0] exp, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         step();
         check_eq(tag, bus.data_o, exp);
      end
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      n_underrun  = 0;
      rst_n       = 1'b0;
      en          = 1'b0;
      rate        = 7'd64;
      bus.data_i  = 16'd1234;
      bus.valid_i = 1'b1;

      // Reset with handshakes offered: nothing may be accepted.
      for (int k = 0; k < 6; k++) begin
         en = k[0];
         step();
         check_eq("rst_data", bus.data_o, 0);
         check_eq("rst_valid", bus.valid_o, 0);
         check_eq("rst_ready", bus.ready_o, 1);
         check_eq("rst_underrun", underrun, 0);
      end
      bus.valid_i = 1'b0;
      en          = 1'b1;
      rst_n       = 1'b1;
      step();
      check_eq("first_strobe_underrun", underrun, 1);
      step();
      check_eq("phase1_no_underrun", underrun, 0);

      // DC gain at R=64.
      restart(7'd64, 16'd1000, 1'b1);
      repeat (800) step();
      for (int k = 0; k < 64; k++) begin
         step();
         check_eq("dc64_data", bus.data_o, 16'd1000);
         check_eq("dc64_valid", bus.valid_o, 1);
      end
      check_eq("dc64_no_underrun", n_underrun, 0);
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("idle_valid", bus.valid_o, 0);
         check_eq("idle_hold", bus.data_o, 16'd1000);
      end

      // R=8 gain and rounding.
      restart(7'd8, 16'd16384, 1'b1);
      repeat (200) step();
      steady_check("r8_16384", 16'd4, 16);
      restart(7'd8, 16'd6144, 1'b1);
      repeat (200) step();
      steady_check("r8_6144", ExpFrac, 16);

      // R=4: backpressure, bypass, underrun. Edge e has phase e%4.
      restart(7'd4, 16'h8000, 1'b1);
      repeat (100) step();
      n_xfer = 0;
      for (int e = 100; e < 140; e++) begin
         did_xfer = bus.valid_i && bus.ready_o;
         step();
         if (did_xfer) n_xfer++;
         check_eq("bp_ready", bus.ready_o, (e % 4) == 0);
      end
      check_eq("bp_xfer_count", n_xfer, 10);
      repeat (60) step();
      check_eq("r4_dc", bus.data_o, ExpNeg);
      step();
      bus.valid_i = 1'b0;
      repeat (3) step();
      bus.valid_i = 1'b1;
      step();
      check_eq("bypass_no_underrun", underrun, 0);
      check_eq("bypass_ready", bus.ready_o, 1);
      step();
      check_eq("after_bypass_accept", bus.ready_o, 0);
      repeat (3) step();
      bus.valid_i = 1'b0;
      repeat (4) step();
      check_eq("underrun_pulse", underrun, 1);
      bus.valid_i = 1'b1;
      step();
      check_eq("underrun_one_cycle", underrun, 0);
      repeat (200) step();
      check_eq("r4_recovered", bus.data_o, ExpNeg);
      check_eq("underrun_count", n_underrun, 1);

      // Rate change 4 -> 16 at phase 1 takes effect after the wrap at edge 11.
      restart(7'd4, 16'd0, 1'b0);
      for (int e = 0; e < 9; e++) begin
         step();
         check_eq("rc_r4_strobe", underrun, (e % 4) == 0);
      end
      rate = 7'd16;
      for (int e = 9; e < 45; e++) begin
         step();
         check_eq("rc_r16_strobe", underrun, (e == 12) || (e == 28) || (e == 44));
      end

      // Clamping: R=0 acts as 2, R=100 acts as 64.
      restart(7'd0, 16'd0, 1'b0);
      for (int e = 0; e < 6; e++) begin
         step();
         check_eq("clamp_lo", underrun, (e % 2) == 0);
      end
      restart(7'd100, 16'd0, 1'b0);
      for (int e = 0; e < 65; e++) begin
         step();
         check_eq("clamp_hi", underrun, (e % 64) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
